// File: rtl/win_rf_pkg.sv
// Shared types and derivations for the windowed register file.
package win_rf_pkg;

  // Spill/fill engine states.
  typedef enum logic [1:0] {
    StIdle,
    StSpill,
    StFill
  } rf_state_e;

  // Number of slices making up one visible window.
  function automatic int unsigned calc_k(int unsigned addr_w, int unsigned stride);
    return (2 ** addr_w) / stride;
  endfunction

  // Total physical registers.
  function automatic int unsigned calc_nphys(int unsigned nwin, int unsigned stride);
    return nwin * stride;
  endfunction

  // Physical register for offset l within the window/slice starting at base*stride.
  function automatic int unsigned phys_idx(int unsigned base, int unsigned l,
                                           int unsigned stride, int unsigned nphys);
    return (base * stride + l) % nphys;
  endfunction

endpackage

// File: rtl/win_rf_spill_ctrl.sv
// Window pointer, resident-slice count, spill stack pointer and the spill/fill handshake FSM.
module win_rf_spill_ctrl
  import win_rf_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned NWIN   = 4,
  parameter int unsigned MEM_AW = 8,
  localparam int unsigned CWP_W  = $clog2(NWIN),
  localparam int unsigned PHYS_W = $clog2(NWIN * STRIDE)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              win_inc_i,
  input  logic              win_dec_i,
  input  logic              mem_ack_i,
  output logic [CWP_W-1:0]  cwp_o,
  output logic              busy_o,
  output logic              win_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [PHYS_W-1:0] xfer_idx_o,
  output logic              fill_we_o
);

  localparam int unsigned K      = calc_k(ADDR_W, STRIDE);
  localparam int unsigned NPHYS  = calc_nphys(NWIN, STRIDE);
  localparam int unsigned CNT_W  = $clog2(NWIN + 1);
  localparam int unsigned SP_W   = MEM_AW + 1;
  localparam int unsigned IDX_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'((2 ** MEM_AW) - STRIDE);

  rf_state_e         state_q, state_d;
  logic [CWP_W-1:0]  cwp_q, cwp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [CWP_W-1:0]  bot;
  logic [CWP_W-1:0]  xfer_slice;
  logic              last_word;

  // Oldest resident slice; wraps naturally because NWIN is a power of two.
  assign bot       = cwp_q - CWP_W'(cnt_q - CNT_W'(K));
  assign last_word = (idx_q == IDX_W'(STRIDE - 1));

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers that move with the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cwp_q <= '0;
      cnt_q <= CNT_W'(K);
      sp_q  <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      cnt_q <= cnt_d;
      sp_q  <= sp_d;
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end

  // Next state: window moves, overflow/underflow decisions, word sequencing.
  always_comb begin
    state_d = state_q;
    cwp_d   = cwp_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (win_inc_i && !win_dec_i) begin
          if (cnt_q < CNT_W'(NWIN)) begin
            cwp_d = cwp_q + CWP_W'(1);
            cnt_d = cnt_q + CNT_W'(1);
          end else if (sp_q > SP_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d = StSpill;
          end
        end else if (win_dec_i && !win_inc_i) begin
          if (cnt_q > CNT_W'(K)) begin
            cwp_d = cwp_q - CWP_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end else if (sp_q != '0) begin
            state_d = StFill;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSpill, StFill: begin
        if (mem_ack_i) begin
          if (last_word) begin
            idx_d   = '0;
            state_d = StIdle;
            // cnt stays put: one slice left (or entered) residency as the window moved.
            if (state_q == StSpill) begin
              sp_d  = sp_q + SP_W'(STRIDE);
              cwp_d = cwp_q + CWP_W'(1);
            end else begin
              sp_d  = sp_q - SP_W'(STRIDE);
              cwp_d = cwp_q - CWP_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: memory handshake and the register-array transfer slot.
  always_comb begin
    busy_o     = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    fill_we_o  = 1'b0;
    xfer_slice = bot;
    mem_addr_o = MEM_AW'(sp_q + SP_W'(idx_q));
    unique case (state_q)
      StIdle: begin
      end
      StSpill: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      StFill: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        fill_we_o  = mem_ack_i;
        xfer_slice = bot - CWP_W'(1);
        mem_addr_o = MEM_AW'(sp_q - SP_W'(STRIDE) + SP_W'(idx_q));
      end
      default: begin
      end
    endcase
  end

  assign xfer_idx_o = PHYS_W'(phys_idx(32'(xfer_slice), 32'(idx_q), STRIDE, NPHYS));
  assign cwp_o      = cwp_q;
  assign win_err_o  = err_q;

endmodule

// File: rtl/win_reg_file.sv
// Windowed register file: overlapping windows over a physical array, with spill/fill of the
// oldest slice to external memory on window overflow/underflow.
module win_reg_file
  import win_rf_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned NWIN   = 4,
  parameter int unsigned MEM_AW = 8,
  localparam int unsigned CWP_W = $clog2(NWIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              win_inc,
  input  logic              win_dec,
  output logic [CWP_W-1:0]  cwp,
  output logic              busy,
  output logic              win_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned NPHYS  = calc_nphys(NWIN, STRIDE);
  localparam int unsigned PHYS_W = $clog2(NPHYS);

  logic [DATA_W-1:0] regs_q [NPHYS];
  logic [DATA_W-1:0] regs_d [NPHYS];
  logic [PHYS_W-1:0] xfer_idx;
  logic              fill_we;
  logic [PHYS_W-1:0] rd_phys1, rd_phys2, wr_phys;

  win_rf_spill_ctrl #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE),
    .NWIN   (NWIN),
    .MEM_AW (MEM_AW)
  ) u_ctrl (
    .clk_i      (clk),
    .rst_ni     (rst),
    .win_inc_i  (win_inc),
    .win_dec_i  (win_dec),
    .mem_ack_i  (mem_ack),
    .cwp_o      (cwp),
    .busy_o     (busy),
    .win_err_o  (win_err),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .xfer_idx_o (xfer_idx),
    .fill_we_o  (fill_we)
  );

  assign rd_phys1 = PHYS_W'(phys_idx(32'(cwp), 32'(rd_addr1), STRIDE, NPHYS));
  assign rd_phys2 = PHYS_W'(phys_idx(32'(cwp), 32'(rd_addr2), STRIDE, NPHYS));
  assign wr_phys  = PHYS_W'(phys_idx(32'(cwp), 32'(wr_addr), STRIDE, NPHYS));

  assign rd_data1  = regs_q[rd_phys1];
  assign rd_data2  = regs_q[rd_phys2];
  assign mem_wdata = regs_q[xfer_idx];

  // Register update: fill data while filling, otherwise datapath writes outside busy.
  always_comb begin
    regs_d = regs_q;
    if (fill_we) begin
      regs_d[xfer_idx] = mem_rdata;
    end else if (wr_en && !busy) begin
      regs_d[wr_phys] = wr_data;
    end
  end

  // Register array storage; async reset clears every physical register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_win_reg_file.sv
// Directed bench for win_reg_file with a small ack-delaying spill memory model.
module tb_win_reg_file;

  logic        clk, rst;
  logic [1:0]  rd_addr1, rd_addr2, wr_addr;
  logic [15:0] rd_data1, rd_data2, wr_data, mem_wdata, mem_rdata;
  logic        wr_en, win_inc, win_dec, busy, win_err, mem_req, mem_we, mem_ack;
  logic [1:0]  cwp;
  logic [7:0]  mem_addr;

  logic [15:0] mem_model [0:255];
  int          n_cmp, n_err;
  int          ack_delay, ack_wait;
  logic        done;

  win_reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .win_inc   (win_inc),
    .win_dec   (win_dec),
    .cwp       (cwp),
    .busy      (busy),
    .win_err   (win_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after ack_delay waiting cycles, updated on the falling edge.
  always @(negedge clk) begin
    if (mem_req && ack_wait >= ack_delay) begin
      mem_ack  = 1'b1;
      ack_wait = 0;
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      else        mem_rdata = mem_model[mem_addr];
    end else if (mem_req) begin
      mem_ack  = 1'b0;
      ack_wait = ack_wait + 1;
    end else begin
      mem_ack  = 1'b0;
      ack_wait = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    rd_addr1 = a;
    #1;
    check_eq(tag, 32'(rd_data1), 32'(exp));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ack_delay = 0; ack_wait = 0; done = 1'b0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; win_inc = 1'b0; win_dec = 1'b0;
    rd_addr1 = 2'd0; rd_addr2 = 2'd3; mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = '0;

    // Reset state.
    #12;
    check_eq("rst_cwp", 32'(cwp), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_win_err", 32'(win_err), 0);
    check_eq("rst_rd1", 32'(rd_data1), 0);
    check_eq("rst_rd2", 32'(rd_data2), 0);
    rst = 1'b1;
    tick();

    // Underflow with empty stack: one-cycle error, nothing moves.
    win_dec = 1'b1;
    tick();
    win_dec = 1'b0;
    check_eq("t5_err_hi", 32'(win_err), 1);
    check_eq("t5_cwp", 32'(cwp), 0);
    check_eq("t5_no_req", 32'(mem_req), 0);
    check_eq("t5_busy", 32'(busy), 0);
    tick();
    check_eq("t5_err_lo", 32'(win_err), 0);
    check_eq("t5_no_req2", 32'(mem_req), 0);

    // Simultaneous inc and dec is a no-op.
    win_inc = 1'b1; win_dec = 1'b1;
    tick();
    win_inc = 1'b0; win_dec = 1'b0;
    check_eq("both_cwp", 32'(cwp), 0);
    check_eq("both_err", 32'(win_err), 0);

    // Window 0 writes, then call: caller r2/r3 become callee r0/r1.
    do_write(2'd2, 16'hBEEF);
    do_write(2'd3, 16'hCAFE);
    do_write(2'd0, 16'h1234);
    do_write(2'd1, 16'h5678);
    read_chk("t1_w0_r2", 2'd2, 16'hBEEF);
    win_inc = 1'b1;
    tick();
    win_inc = 1'b0;
    check_eq("t1_cwp", 32'(cwp), 1);
    read_chk("t1_overlap_r0", 2'd0, 16'hBEEF);
    read_chk("t1_overlap_r1", 2'd1, 16'hCAFE);

    // Third call from reset overflows: spill slice 0 to addresses 0,1.
    win_inc = 1'b1;
    tick();
    check_eq("t2_cwp2", 32'(cwp), 2);
    check_eq("t2_busy0", 32'(busy), 0);
    tick();
    win_inc = 1'b0;
    check_eq("t2_busy_w0", 32'(busy), 1);
    check_eq("t2_req_w0", 32'(mem_req), 1);
    check_eq("t2_we_w0", 32'(mem_we), 1);
    check_eq("t2_addr_w0", 32'(mem_addr), 0);
    check_eq("t2_data_w0", 32'(mem_wdata), 32'h1234);
    check_eq("t2_cwp_hold", 32'(cwp), 2);
    tick();
    check_eq("t2_busy_w1", 32'(busy), 1);
    check_eq("t2_addr_w1", 32'(mem_addr), 1);
    check_eq("t2_data_w1", 32'(mem_wdata), 32'h5678);
    tick();
    check_eq("t2_busy_end", 32'(busy), 0);
    check_eq("t2_req_end", 32'(mem_req), 0);
    check_eq("t2_cwp3", 32'(cwp), 3);
    check_eq("t2_mem0", 32'(mem_model[0]), 32'h1234);
    check_eq("t2_mem1", 32'(mem_model[1]), 32'h5678);

    // Overwrite phys0 via window 3, then return three times: fill restores slice 0.
    do_write(2'd2, 16'h1111);
    read_chk("t4_w3_r2", 2'd2, 16'h1111);
    win_dec = 1'b1;
    tick();
    check_eq("t4_cwp2", 32'(cwp), 2);
    tick();
    check_eq("t4_cwp1", 32'(cwp), 1);
    check_eq("t4_busy0", 32'(busy), 0);
    tick();
    win_dec = 1'b0;
    check_eq("t4_busy_w0", 32'(busy), 1);
    check_eq("t4_req_w0", 32'(mem_req), 1);
    check_eq("t4_we_w0", 32'(mem_we), 0);
    check_eq("t4_addr_w0", 32'(mem_addr), 0);
    check_eq("t4_cwp_hold", 32'(cwp), 1);
    tick();
    check_eq("t4_addr_w1", 32'(mem_addr), 1);
    check_eq("t4_busy_w1", 32'(busy), 1);
    tick();
    check_eq("t4_busy_end", 32'(busy), 0);
    check_eq("t4_cwp0", 32'(cwp), 0);
    read_chk("t4_r0", 2'd0, 16'h1234);
    read_chk("t4_r1", 2'd1, 16'h5678);
    read_chk("t4_r2", 2'd2, 16'hBEEF);

    // Stalled spill: outputs hold, writes ignored while busy.
    mem_model[0] = '0;
    mem_model[1] = '0;
    win_inc = 1'b1;
    tick();
    tick();
    check_eq("t3_cwp2", 32'(cwp), 2);
    ack_delay = 3;
    tick();
    win_inc = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hDEAD;
    check_eq("t3_req_s0", 32'(mem_req), 1);
    check_eq("t3_addr_s0", 32'(mem_addr), 0);
    check_eq("t3_data_s0", 32'(mem_wdata), 32'h1234);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq($sformatf("t3_req_s%0d", k), 32'(mem_req), 1);
      check_eq($sformatf("t3_busy_s%0d", k), 32'(busy), 1);
      check_eq($sformatf("t3_we_s%0d", k), 32'(mem_we), 1);
      check_eq($sformatf("t3_addr_s%0d", k), 32'(mem_addr), 0);
      check_eq($sformatf("t3_data_s%0d", k), 32'(mem_wdata), 32'h1234);
    end
    tick();
    check_eq("t3_addr_w1", 32'(mem_addr), 1);
    check_eq("t3_data_w1", 32'(mem_wdata), 32'h5678);
    for (int k = 0; k < 20 && busy; k++) tick();
    check_eq("t3_done", 32'(busy), 0);
    wr_en = 1'b0;
    check_eq("t3_cwp3", 32'(cwp), 3);
    check_eq("t3_mem0", 32'(mem_model[0]), 32'h1234);
    check_eq("t3_mem1", 32'(mem_model[1]), 32'h5678);
    read_chk("t3_wr_ignored", 2'd0, 16'h0000);

    // Reset mid-spill: everything clears without a clock edge.
    rd_addr1 = 2'd2; rd_addr2 = 2'd0;
    win_inc = 1'b1;
    tick();
    win_inc = 1'b0;
    check_eq("t6_busy", 32'(busy), 1);
    check_eq("t6_addr_sp", 32'(mem_addr), 2);
    check_eq("t6_data", 32'(mem_wdata), 32'hBEEF);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_req", 32'(mem_req), 0);
    check_eq("t6_busy0", 32'(busy), 0);
    check_eq("t6_cwp", 32'(cwp), 0);
    check_eq("t6_rd1", 32'(rd_data1), 0);
    check_eq("t6_rd2", 32'(rd_data2), 0);
    #2;
    rst = 1'b1;
    tick();
    check_eq("t6_idle_busy", 32'(busy), 0);
    check_eq("t6_idle_req", 32'(mem_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    done = 1'b1;
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
    end
  end

endmodule
